// File: rtl/addsub_serie.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// Subtraction runs as a + ~b + ~c_in; c_out reports the borrow for subtract.
module addsub_serie #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             op_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_nxt;

  always_comb begin
    sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op_r     <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= op ? ~b : b;
            op_r  <= op;
            carry <= op ? ~c_in : c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // On the MSB step, carry holds the carry into the MSB.
            result   <= {sum_bit, res_sr[WIDTH-1:1]};
            c_out    <= op_r ? ~carry_nxt : carry_nxt;
            overflow <= carry ^ carry_nxt;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serie.sv
// Self-checking bench for addsub_serie: directed table, corner sequences and
// random operations compared against an integer-arithmetic reference.
module tb_addsub_serie;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_r;
  logic         prev_co;
  logic         prev_ov;

  addsub_serie #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .c_in(c_in), .result(result), .c_out(c_out), .overflow(overflow),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         b2b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic ci, output logic [W-1:0] r,
                                output logic co, output logic ov);
    int lim = 1 << (W - 1);
    int ua = int'(av);
    int ub = int'(bv);
    int sa = (ua >= lim) ? ua - 2 * lim : ua;
    int sb = (ub >= lim) ? ub - 2 * lim : ub;
    int u;
    int s;
    if (!o) begin
      u  = ua + ub + int'(ci);
      s  = sa + sb + int'(ci);
      co = (u >= 2 * lim);
    end else begin
      u  = ua - ub - int'(ci);
      s  = sa - sb - int'(ci);
      co = (u < 0);
    end
    r  = W'(u);
    ov = (s >= lim) || (s < -lim);
  endfunction

  // Entered at the first negedge after the accepting edge; returns at the done negedge.
  task automatic wait_done(input string tag, input logic [W-1:0] er, input logic eco,
                           input logic eov);
    int  n = 0;
    bit  seen = 0;
    check({tag, ".accept_busy"}, 32'(busy), 32'd1);
    check({tag, ".accept_nodone"}, 32'(done), 32'd0);
    for (int i = 0; i < 3 * W + 4; i++) begin
      check({tag, ".busy_done_excl"}, 32'(busy & done), 32'd0);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) begin
        n++;
        check({tag, ".held_result"}, 32'({result, c_out, overflow}),
              32'({prev_r, prev_co, prev_ov}));
      end
      @(negedge clk);
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(n), 32'(W));
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".c_out"}, 32'(c_out), 32'(eco));
    check({tag, ".overflow"}, 32'(overflow), 32'(eov));
    prev_r  = er;
    prev_co = eco;
    prev_ov = eov;
  endtask

  // Called at a negedge; the following posedge accepts the operation.
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ci, input logic [W-1:0] er,
                       input logic eco, input logic eov);
    op = o; a = av; b = bv; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 1'($urandom); c_in = 1'($urandom);
    wait_done(tag, er, eco, eov);
  endtask

  initial begin
    vec_t         tbl[7];
    logic [W-1:0] mr;
    logic         mco;
    logic         mov;
    logic         ro;
    logic         rci;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    tbl[0] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 4'b0101, 4'b1010, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 4'b1010, 4'b0011, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; c_in = 1'b0;
    prev_r = '0; prev_co = 1'b0; prev_ov = 1'b0;
    @(negedge clk);
    check("rst.result", 32'(result), 32'd0);
    check("rst.c_out", 32'(c_out), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (!tbl[i].b2b) @(negedge clk);
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin,
            tbl[i].res, tbl[i].co, tbl[i].ov);
    end

    // start held high through CALC with operands changing underneath
    @(negedge clk);
    op = 1'b1; a = 4'b0101; b = 4'b0010; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'b1111;
    wait_done("hold1", 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done("hold2", 4'b1101, 1'b0, 1'b0);

    // asynchronous reset after two CALC edges
    @(negedge clk);
    op = 1'b0; a = 4'b0001; b = 4'b0001; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst.result", 32'(result), 32'd0);
    check("arst.c_out", 32'(c_out), 32'd0);
    check("arst.overflow", 32'(overflow), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    @(negedge clk);
    #3 reset = 1'b0;
    prev_r = '0; prev_co = 1'b0; prev_ov = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check("arst.quiet", 32'({busy, done}), 32'd0);
    end
    do_op("post_rst", 1'b0, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);

    // random operations, some issued back-to-back from the done cycle
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom); ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
      model(ro, ra, rb, rci, mr, mco, mov);
      if ($urandom_range(1, 0) == 0) @(negedge clk);
      do_op($sformatf("rnd%0d", i), ro, ra, rb, rci, mr, mco, mov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
